// File: rtl/id_ex_shift_operand_stage.sv
// rtl/id_ex_shift_operand_stage.sv - ID/EX register with RAW forwarding feeding the EX shifter.
module id_ex_shift_operand_stage #(
   parameter logic [5:0] FUNCT_SLL  = 6'b000000,
   parameter logic [5:0] FUNCT_SLLV = 6'b000100,
   parameter logic [5:0] SIG_IDLE   = 6'b111111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [5:0]  id_funct,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [4:0]  id_shamt,
   input  logic        id_reg_write,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   output logic        ex_valid,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic [31:0] shift_A,
   output logic [31:0] shift_B,
   output logic [5:0]  shift_Signal
);

   logic        valid_q,     valid_d;
   logic [5:0]  funct_q,     funct_d;
   logic [4:0]  rs_q,        rs_d;
   logic [4:0]  rt_q,        rt_d;
   logic [4:0]  rd_q,        rd_d;
   logic [4:0]  shamt_q,     shamt_d;
   logic        reg_write_q, reg_write_d;
   logic [31:0] rs_data_q,   rs_data_d;
   logic [31:0] rt_data_q,   rt_data_d;

   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic        is_sll;
   logic        is_sllv;
   logic        unused_rs_hi;

   // Flush only kills valid/reg_write; the data fields keep their old values.
   always_comb begin
      valid_d     = valid_q;
      funct_d     = funct_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      shamt_d     = shamt_q;
      reg_write_d = reg_write_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (!stall) begin
         valid_d     = id_valid;
         funct_d     = id_funct;
         rs_d        = id_rs;
         rt_d        = id_rt;
         rd_d        = id_rd;
         shamt_d     = id_shamt;
         reg_write_d = id_reg_write;
         rs_data_d   = id_rs_data;
         rt_data_d   = id_rt_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q     <= 1'b0;
         funct_q     <= 6'd0;
         rs_q        <= 5'd0;
         rt_q        <= 5'd0;
         rd_q        <= 5'd0;
         shamt_q     <= 5'd0;
         reg_write_q <= 1'b0;
         rs_data_q   <= 32'd0;
         rt_data_q   <= 32'd0;
      end else begin
         valid_q     <= valid_d;
         funct_q     <= funct_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         shamt_q     <= shamt_d;
         reg_write_q <= reg_write_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
      end
   end

   // Nearer producer (EX/MEM) wins; $0 is hardwired and never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_q)) begin
         fwd_rs = exmem_result;
      end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_q)) begin
         fwd_rs = memwb_result;
      end
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_q)) begin
         fwd_rt = exmem_result;
      end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_q)) begin
         fwd_rt = memwb_result;
      end
   end

   assign is_sll  = (funct_q == FUNCT_SLL);
   assign is_sllv = (funct_q == FUNCT_SLLV);

   always_comb begin
      shift_B = 32'd0;
      if (is_sll) begin
         shift_B = {27'd0, shamt_q};
      end else if (is_sllv) begin
         shift_B = {27'd0, fwd_rs[4:0]};
      end
   end

   always_comb begin
      shift_Signal = funct_q;
      if (!valid_q) begin
         shift_Signal = SIG_IDLE;
      end else if (is_sll || is_sllv) begin
         shift_Signal = 6'b000000;
      end
   end

   // Only the low five bits of rs act as a shift amount.
   assign unused_rs_hi = ^fwd_rs[31:5];

   assign shift_A      = fwd_rt;
   assign ex_valid     = valid_q;
   assign ex_rd        = rd_q;
   assign ex_reg_write = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_shift_operand_stage.sv
// tb/tb_id_ex_shift_operand_stage.sv - Table-driven scoreboard bench for id_ex_shift_operand_stage.
module tb_id_ex_shift_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_shamt;
   logic        id_reg_write;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_result;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic [31:0] shift_A;
   logic [31:0] shift_B;
   logic [5:0]  shift_Signal;

   id_ex_shift_operand_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_shamt(id_shamt), .id_reg_write(id_reg_write),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .shift_A(shift_A), .shift_B(shift_B), .shift_Signal(shift_Signal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  funct;
      logic [4:0]  rs, rt, rd, shamt;
      logic        rw, valid;
      logic [31:0] rs_data, rt_data;
      logic        xw;
      logic [4:0]  xrd;
      logic [31:0] xres;
      logic        ww;
      logic [4:0]  wrd;
      logic [31:0] wres;
   } stim_t;

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] a, b;
      logic [5:0]  sig;
   } exp_t;

   stim_t stims[8];
   exp_t  exps[8];
   exp_t  sb[$];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic stim_t mk_s(logic [5:0] funct, logic [4:0] rs, logic [4:0] rt,
                                  logic [4:0] rd, logic [4:0] shamt, logic rw, logic valid,
                                  logic [31:0] rs_data, logic [31:0] rt_data,
                                  logic xw, logic [4:0] xrd, logic [31:0] xres,
                                  logic ww, logic [4:0] wrd, logic [31:0] wres);
      stim_t s;
      s.funct = funct; s.rs = rs; s.rt = rt; s.rd = rd; s.shamt = shamt;
      s.rw = rw; s.valid = valid; s.rs_data = rs_data; s.rt_data = rt_data;
      s.xw = xw; s.xrd = xrd; s.xres = xres; s.ww = ww; s.wrd = wrd; s.wres = wres;
      return s;
   endfunction

   function automatic exp_t mk_e(logic valid, logic [4:0] rd, logic rw,
                                 logic [31:0] a, logic [31:0] b, logic [5:0] sig);
      exp_t e;
      e.valid = valid; e.rd = rd; e.rw = rw; e.a = a; e.b = b; e.sig = sig;
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: scoreboard empty, got valid=%b expected an entry", tag, ex_valid);
      end else begin
         e = sb.pop_front();
         cmp({tag, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, e.valid});
         cmp({tag, ".ex_rd"},        {27'd0, ex_rd},        {27'd0, e.rd});
         cmp({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
         cmp({tag, ".shift_A"},      shift_A,               e.a);
         cmp({tag, ".shift_B"},      shift_B,               e.b);
         cmp({tag, ".shift_Signal"}, {26'd0, shift_Signal}, {26'd0, e.sig});
      end
   endtask

   task automatic drive_id(input stim_t s);
      id_valid = s.valid; id_funct = s.funct; id_rs = s.rs; id_rt = s.rt;
      id_rd = s.rd; id_shamt = s.shamt; id_reg_write = s.rw;
      id_rs_data = s.rs_data; id_rt_data = s.rt_data;
   endtask

   task automatic drive_fwd(input stim_t s);
      exmem_reg_write = s.xw; exmem_rd = s.xrd; exmem_result = s.xres;
      memwb_reg_write = s.ww; memwb_rd = s.wrd; memwb_result = s.wres;
   endtask

   // ID fields go in before the edge; forwarding inputs belong to the EX cycle after it.
   task automatic step(input stim_t s, input logic st, input logic fl,
                       input exp_t e, input string tag);
      @(negedge clk);
      drive_id(s);
      stall = st;
      flush = fl;
      sb.push_back(e);
      @(posedge clk);
      #1 drive_fwd(s);
      #1 check_out(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      stim_t s_load, s_a, s_b, s_c;
      exp_t  e_load;

      //          funct  rs  rt  rd  sh  rw v  rs_data        rt_data        xw xrd xres           ww wrd wres
      stims[0] = mk_s(6'h00, 1, 2,  5,  4, 1, 1, 32'h10,        32'h3,         0, 0, 32'h0,         0, 0, 32'h0);
      stims[1] = mk_s(6'h04, 8, 8,  9,  7, 1, 1, 32'h55,        32'h66,        1, 8, 32'h22,        1, 8, 32'hFFFF_FFFF);
      stims[2] = mk_s(6'h00, 0, 0,  3,  1, 1, 1, 32'h0,         32'h0,         1, 0, 32'hDEAD_BEEF, 1, 0, 32'h1234);
      stims[3] = mk_s(6'h04, 3, 4,  6,  0, 0, 1, 32'hFFFF_FFE5, 32'h100,       0, 3, 32'hAAAA,      1, 3, 32'h47);
      stims[4] = mk_s(6'h04, 5, 6, 11,  2, 1, 1, 32'hFFFF_FFE5, 32'h1234,      1, 7, 32'h1,         0, 6, 32'h9);
      stims[5] = mk_s(6'h20, 1, 2,  7,  9, 1, 1, 32'h0,         32'hABCD,      0, 0, 32'h0,         1, 2, 32'h77);
      stims[6] = mk_s(6'h00, 0, 0, 10,  3, 1, 0, 32'h0,         32'h5,         0, 0, 32'h0,         0, 0, 32'h0);
      stims[7] = mk_s(6'h00, 0, 9, 31, 31, 1, 1, 32'h0,         32'h5,         1, 9, 32'h99,        0, 9, 32'h11);

      exps[0] = mk_e(1,  5, 1, 32'h3,    32'd4,  6'h00);
      exps[1] = mk_e(1,  9, 1, 32'h22,   32'd2,  6'h00);
      exps[2] = mk_e(1,  3, 1, 32'h0,    32'd1,  6'h00);
      exps[3] = mk_e(1,  6, 0, 32'h100,  32'd7,  6'h00);
      exps[4] = mk_e(1, 11, 1, 32'h1234, 32'd5,  6'h00);
      exps[5] = mk_e(1,  7, 1, 32'h77,   32'd0,  6'h20);
      exps[6] = mk_e(0, 10, 0, 32'h5,    32'd3,  6'h3F);
      exps[7] = mk_e(1, 31, 1, 32'h99,   32'd31, 6'h00);

      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      drive_id(stims[0]);
      drive_fwd(stims[6]);
      #2 reset = 1'b1;
      #1;
      sb.push_back(mk_e(0, 0, 0, 32'h0, 32'h0, 6'h3F));
      check_out("reset");

      for (int i = 0; i < 8; i++) begin
         step(stims[i], 1'b0, 1'b0, exps[i], $sformatf("vec%0d", i));
      end

      s_load = stims[0];
      e_load = exps[0];
      s_a = mk_s(6'h20, 7, 7, 12, 10, 0, 1, 32'h0, 32'hFFFF, 0, 0, 32'h0, 0, 0, 32'h0);
      s_b = s_a;
      s_b.xw = 1'b1; s_b.xrd = 5'd2; s_b.xres = 32'h40;
      s_c = s_a;
      step(s_load, 1'b0, 1'b0, e_load, "stall_load");
      step(s_a, 1'b1, 1'b0, e_load, "stall1");
      step(s_b, 1'b1, 1'b0, mk_e(1, 5, 1, 32'h40, 32'd4, 6'h00), "stall2_fwd");
      step(s_c, 1'b1, 1'b1, mk_e(0, 5, 0, 32'h3, 32'd4, 6'h3F), "flush_stall");
      step(s_load, 1'b0, 1'b0, e_load, "after_flush");

      #1 reset = 1'b0;
      #1;
      sb.push_back(mk_e(0, 0, 0, 32'h0, 32'h0, 6'h3F));
      check_out("mid_reset");
      @(negedge clk);
      reset = 1'b1;
      step(stims[1], 1'b0, 1'b0, exps[1], "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
